// File: rtl/dmem_byte_engine.sv
// -----------------------------------------------------------------------------
// dmem_byte_engine
//
// Byte-addressable data memory for the MEM stage. Storage has a single
// byte-wide port, so an N-byte access is serialised over N cycles by a small
// FSM (IDLE -> XFER -> RESP). Reads are zero- or sign-extended to DATA_W.
//
// Parameters
//   DATA_W  access width in bits (multiple of 8, 8..64)
//   ADDR_W  request address width
//   DEPTH   storage size in bytes (power of two, >= 2, <= 2**ADDR_W)
//
// Ports
//   clk          clock, rising edge
//   reset        asynchronous active-high reset
//   req_valid    request present
//   req_ready    engine idle and able to accept a request
//   req_write    1 = write, 0 = read
//   req_size     log2 of the byte count
//   req_signed   reads: 1 = sign-extend, 0 = zero-extend
//   req_addr     byte address of the lowest byte
//   req_wdata    write data, little-endian
//   resp_valid   one-cycle response pulse (reads and writes)
//   resp_rdata   read result; 0 for writes and errors
//   resp_err     request was rejected
//
// Optional feature
//   DMEM_ALIGN_CHECK_EN  when defined, an address that is not a multiple of
//                        the access size is rejected with an error response.
// -----------------------------------------------------------------------------
module dmem_byte_engine #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err
);

    localparam int unsigned NumBytes = DATA_W / 8;
    localparam int unsigned AddrLsb  = $clog2(DEPTH);
    localparam int unsigned MemAw    = (AddrLsb > 0) ? AddrLsb : 1;

    typedef enum logic [1:0] {
        StIdle,
        StXfer,
        StResp
    } state_e;

    // -------------------------------------------------------------------------
    // Request decode and error detection (evaluated in IDLE, used at T0)
    // -------------------------------------------------------------------------
    logic [3:0] req_nbytes;
    logic       size_err;
    logic       range_err;
    logic       align_err;
    logic       req_err;

    always_comb begin
        req_nbytes = 4'd1 << req_size;
        size_err   = 32'(req_nbytes) > NumBytes;
    end

    // Any address bit above the storage index range makes the request invalid.
    if (AddrLsb < ADDR_W) begin : g_range_chk
        assign range_err = |req_addr[ADDR_W-1:AddrLsb];
    end else begin : g_no_range_chk
        assign range_err = 1'b0;
    end

`ifdef DMEM_ALIGN_CHECK_EN
    // Low address bits must be zero under the access-size mask.
    assign align_err = |(3'(req_addr) & 3'(req_nbytes - 4'd1));
`else
    assign align_err = 1'b0;
`endif

    assign req_err = size_err | range_err | align_err;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e             state_q;
    logic               write_q;
    logic [3:0]         nbytes_q;
    logic               signed_q;
    logic [MemAw-1:0]   addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [2:0]         cnt_q;
    logic [DATA_W-1:0]  acc_q;
    logic               resp_valid_q;
    logic [DATA_W-1:0]  resp_rdata_q;
    logic               resp_err_q;

    assign req_ready  = (state_q == StIdle);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

    // -------------------------------------------------------------------------
    // Byte storage: one port, shared by reads and writes. Not reset.
    // -------------------------------------------------------------------------
    logic [7:0]       mem [DEPTH];
    logic [MemAw-1:0] mem_addr;
    logic [7:0]       mem_rbyte;
    logic [7:0]       wr_byte;
    logic             mem_we;
    logic             last_byte;

    // Address arithmetic is modulo DEPTH, so wrapping accesses fall out here.
    assign mem_addr  = addr_q + MemAw'(cnt_q);
    assign mem_rbyte = mem[mem_addr];
    assign wr_byte   = 8'(wdata_q >> {cnt_q, 3'b000});
    assign mem_we    = (state_q == StXfer) && write_q;
    assign last_byte = (cnt_q == 3'(nbytes_q - 4'd1));

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= wr_byte;
        end
    end

    // -------------------------------------------------------------------------
    // Read assembly and extension. rdata_asm merges the byte being read this
    // cycle into the accumulator so the final value is ready on the last edge.
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] rdata_asm;
    logic [DATA_W-1:0] rdata_ext;
    logic              sign_bit;

    always_comb begin
        rdata_asm = acc_q;
        for (int b = 0; b < int'(NumBytes); b++) begin
            if (b == int'(cnt_q)) begin
                rdata_asm[8*b +: 8] = mem_rbyte;
            end
        end

        sign_bit = 1'b0;
        for (int b = 0; b < int'(NumBytes); b++) begin
            if (b == int'(nbytes_q) - 1) begin
                sign_bit = rdata_asm[8*b+7];
            end
        end

        rdata_ext = rdata_asm;
        for (int b = 0; b < int'(NumBytes); b++) begin
            if (b >= int'(nbytes_q)) begin
                rdata_ext[8*b +: 8] = {8{sign_bit & signed_q}};
            end
        end
    end

    // -------------------------------------------------------------------------
    // Control FSM with registered response outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            write_q      <= 1'b0;
            nbytes_q     <= 4'd0;
            signed_q     <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= 3'd0;
            acc_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        write_q  <= req_write;
                        nbytes_q <= req_nbytes;
                        signed_q <= req_signed;
                        addr_q   <= MemAw'(req_addr);
                        wdata_q  <= req_wdata;
                        cnt_q    <= 3'd0;
                        acc_q    <= '0;
                        if (req_err) begin
                            state_q      <= StResp;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                        end else begin
                            state_q <= StXfer;
                        end
                    end
                end

                StXfer: begin
                    if (!write_q) begin
                        acc_q <= rdata_asm;
                    end
                    if (last_byte) begin
                        state_q      <= StResp;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= write_q ? '0 : rdata_ext;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end

                StResp: begin
                    resp_valid_q <= 1'b0;
                    state_q      <= StIdle;
                end

                default: begin
                    state_q      <= StIdle;
                    resp_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
